// File: rtl/hsv_frame_ctrl.sv
// Frame sequencer for the rgb2hsv core: streams every pixel of the source RAM
// through the core under a valid handshake and writes each result to the sink RAM.
module hsv_frame_ctrl #(
  parameter int WIDTH   = 100,
  parameter int HEIGHT  = 100,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       pix_count,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [3*DATA_W-1:0]   rd_data,
  output logic                  core_valid_in,
  output logic [DATA_W-1:0]     core_r,
  output logic [DATA_W-1:0]     core_g,
  output logic [DATA_W-1:0]     core_b,
  input  logic [DATA_W-1:0]     core_h,
  input  logic [DATA_W-1:0]     core_s,
  input  logic [DATA_W-1:0]     core_v,
  input  logic                  core_valid_out,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [3*DATA_W-1:0]   wr_data
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_CNT  = (ADDR_W+1)'(NPIX);
  localparam logic [TW-1:0]     TMO_MAX   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_WRITE, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tmo;

  // Outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      tmo           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      pix_count     <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      core_valid_in <= 1'b0;
      core_r        <= '0;
      core_g        <= '0;
      core_b        <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (abort && state != S_IDLE) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        core_valid_in <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            error     <= 1'b0;
            pix_count <= '0;
            addr      <= '0;
            rd_addr   <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            core_r        <= rd_data[3*DATA_W-1:2*DATA_W];
            core_g        <= rd_data[2*DATA_W-1:DATA_W];
            core_b        <= rd_data[DATA_W-1:0];
            core_valid_in <= 1'b1;
            tmo           <= '0;
            state         <= S_WAIT;
          end
          S_WAIT: begin
            if (core_valid_out) begin
              wr_data       <= {core_h, core_s, core_v};
              wr_addr       <= addr;
              wr_en         <= 1'b1;
              core_valid_in <= 1'b0;
              if (pix_count != NPIX_CNT) pix_count <= pix_count + 1'b1;
              state         <= S_WRITE;
            end else if (tmo == TMO_MAX) begin
              error         <= 1'b1;
              core_valid_in <= 1'b0;
              state         <= S_ERR;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_WRITE: begin
            tmo   <= '0;
            state <= S_DRAIN;
          end
          // A valid_out left high from this pixel must fall before the next fetch.
          S_DRAIN: begin
            if (!core_valid_out) begin
              if (addr == LAST_ADDR) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                addr    <= addr + 1'b1;
                rd_addr <= addr + 1'b1;
                rd_en   <= 1'b1;
                state   <= S_FETCH;
              end
            end else if (tmo == TMO_MAX) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_DONE: state <= S_IDLE;
          S_ERR: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hsv_frame_ctrl.md
# hsv_frame_ctrl

Frame sequencer for the `rgb2hsv` conversion core. On a `start` pulse it walks a pixel source memory from address 0 to WIDTH*HEIGHT-1 and presents each packed {r,g,b} word to the core. It holds each pixel on the core inputs until the core reports `valid_out`, then writes the packed {h,s,v} result to a sink memory at the same address. The block replaces the hand-timed, fixed-delay pixel loop with a handshaked, timeout-guarded controller usable in hardware.

## Interface
Parameters:
- WIDTH, 100, pixels per line
- HEIGHT, 100, lines per frame
- DATA_W, 32, width of each colour/HSV component
- ADDR_W, 14, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- TIMEOUT, 63, maximum cycles to wait for any core handshake edge

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start request
- abort  in  1  stop the current frame immediately
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the last pixel is written
- error  out  1  sticky timeout flag; cleared by an accepted start
- pix_count  out  ADDR_W+1  pixels written in the current or last frame
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source read address
- rd_data  in  3*DATA_W  {r,g,b}, valid the cycle after rd_en (synchronous RAM)
- core_valid_in  out  1  to `rgb2hsv` valid_in
- core_r, core_g, core_b  out  DATA_W each  to the core
- core_h, core_s, core_v  in  DATA_W each  from the core
- core_valid_out  in  1  from the core valid_out
- wr_en  out  1  sink write strobe
- wr_addr  out  ADDR_W  sink write address
- wr_data  out  3*DATA_W  {h,s,v}

## Operation
- All outputs are registered. Reset values are all 0, and the state is IDLE.
- States:
  - IDLE: on `start`, clear `error`, `pix_count` and the address, then go to FETCH.
  - FETCH: drive rd_en=1 and rd_addr=addr, then go to LOAD.
  - LOAD: register rd_data[3*DATA_W-1:2*DATA_W]→core_r, the middle field→core_g and the low field→core_b. Set core_valid_in=1 and go to WAIT.
  - WAIT: core inputs are held stable and core_valid_in=1. When core_valid_out=1, capture {core_h,core_s,core_v}→wr_data and addr→wr_addr, then go to WRITE. If TIMEOUT cycles elapse in WAIT without core_valid_out, go to ERR.
  - WRITE: drive wr_en=1 for this cycle only and set core_valid_in=0. Increment `pix_count`, then go to DRAIN.
  - DRAIN: core_valid_in=0. When core_valid_out=0, go to DONE if addr = WIDTH*HEIGHT-1; otherwise increment addr and go to FETCH. If TIMEOUT cycles elapse in DRAIN with core_valid_out still 1, go to ERR.
  - DONE: done=1 for one cycle, then go to IDLE.
  - ERR: set error=1 and core_valid_in=0, then go to IDLE. No done pulse is issued.
- The timeout counter is cleared on every entry to WAIT or DRAIN. The timeout fires on the cycle the count reaches TIMEOUT.
- core_valid_out is ignored outside WAIT and DRAIN. DRAIN guarantees that a stale high valid_out from the previous pixel is never accepted as the next pixel's result.
- `start` is ignored when not IDLE.
- `abort` takes effect from any non-IDLE state: the next state is IDLE, with core_valid_in=0 and wr_en=0. There is no done pulse and `error` is unchanged. A WRITE in progress on the abort cycle is suppressed.
- If `start` and `abort` are high together in IDLE, abort wins and the block stays IDLE.
- `pix_count` saturates at WIDTH*HEIGHT and holds its value after DONE, ERR or abort until the next accepted start.
- Reset mid-frame: the block enters IDLE immediately and all outputs go to 0. The sink memory may hold a partial frame.

## Timing
- Start acceptance: the cycle `start` is sampled high in IDLE is cycle 0. busy=1 and rd_en=1 (FETCH) from cycle 1.
- Per-pixel sequence, for a core that raises valid_out L cycles after valid_in rises (L ≥ 1) and drops it one cycle after valid_in falls:
  - FETCH: 1 cycle
  - LOAD: 1 cycle
  - WAIT: L cycles
  - WRITE: 1 cycle
  - DRAIN: 2 cycles
- Pixel period is therefore L+5 cycles.
- wr_en for pixel n falls L+3 cycles after rd_en for pixel n.
- done is asserted the cycle after the final DRAIN exit. busy drops in the same cycle done is high.
- The error path takes TIMEOUT+1 cycles from WAIT entry to error=1.

## Test plan
- WIDTH=4, HEIGHT=4, behavioural core with L=5, source word i = {i, 2i, 3i} → 16 writes at wr_addr 0..15 in order, each with wr_data equal to the model HSV. Writes are 10 cycles apart, there is exactly one done pulse, pix_count=16 and error=0.
- Core that never asserts valid_out, TIMEOUT=63 → no wr_en. error=1 occurs 64 cycles after WAIT entry, then IDLE with busy=0, done=0 and pix_count=0.
- Core with valid_out stuck high → pixel 0 is written once, then DRAIN times out, giving error=1 and pix_count=1. The next start clears error.
- abort asserted in WAIT of pixel 7 → the next cycle is IDLE with core_valid_in=0. There is no further wr_en, pix_count=7 and no done pulse.
- start pulsed in FETCH and in WRITE of an active frame → ignored, and the frame completes normally with 16 writes.
- rst raised asynchronously mid-WAIT → all outputs are 0 before the next clock edge. A fresh start after reset is released gives the full correct 16-pixel frame.
